feature_stream_loader: RTL and testbench



---
 rtl/feature_stream_loader.sv | 95 +++++++++
 tb/tb_feature_stream_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_stream_loader.sv
// rtl/feature_stream_loader.sv - serial feature loader and result returner for a combinational classifier
// Optional feature: OUT_PLUS_ONE_EN selects 1-based class labels on m_data.
module feature_stream_loader #(
  parameter int WIDTH_A  = 4,
  parameter int NUM_A    = 21,
  parameter int OUTWIDTH = 2,
  parameter int SETTLE   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH_A-1:0]         s_data,
  output logic [NUM_A*WIDTH_A-1:0]   cls_inp,
  input  logic [OUTWIDTH-1:0]        cls_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUTWIDTH:0]          m_data,
  output logic [15:0]                frame_cnt
);

  localparam int IDXW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_A - 1);
  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUT} state_t;

  state_t state, state_nxt;
  logic [IDXW-1:0] idx;
  logic [7:0] cnt;
  logic [OUTWIDTH:0] result;
  logic accept, deliver;

`ifdef OUT_PLUS_ONE_EN
  assign result = {1'b0, cls_out} + {{OUTWIDTH{1'b0}}, 1'b1};
`else
  assign result = {1'b0, cls_out};
`endif

  assign accept  = s_valid && s_ready;
  assign deliver = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (s_valid && idx == IDX_LAST) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == CNT_LAST)            state_nxt = ST_OUT;
      ST_OUT:    if (m_ready)                    state_nxt = ST_LOAD;
      default:                                   state_nxt = ST_LOAD;
    endcase
  end

  // Handshake outputs depend only on the state register; rst forces both low.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    if (!rst) begin
      s_ready = (state == ST_LOAD);
      m_valid = (state == ST_OUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      cnt       <= '0;
      cls_inp   <= '0;
      m_data    <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_A; i++) begin
          if (idx == IDXW'(i)) cls_inp[i*WIDTH_A +: WIDTH_A] <= s_data;
        end
        if (idx == IDX_LAST) begin
          idx <= '0;
          cnt <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (state == ST_SETTLE) begin
        cnt <= cnt + 8'd1;
        if (cnt == CNT_LAST) m_data <= result;
      end
      if (deliver) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_feature_stream_loader.sv
// tb/tb_feature_stream_loader.sv - scoreboard bench for feature_stream_loader
module tb_feature_stream_loader;

  localparam int WIDTH_A  = 4;
  localparam int NUM_A    = 21;
  localparam int OUTWIDTH = 2;
  localparam int SETTLE   = 4;
  localparam int PERIOD   = NUM_A + SETTLE + 1;

  logic clk = 1'b0;
  logic rst;
  logic s_valid;
  logic s_ready;
  logic [WIDTH_A-1:0] s_data;
  logic [NUM_A*WIDTH_A-1:0] cls_inp;
  logic [OUTWIDTH-1:0] cls_out;
  logic m_valid;
  logic m_ready;
  logic [OUTWIDTH:0] m_data;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [OUTWIDTH:0] exp_q[$];
  logic [NUM_A*WIDTH_A-1:0] exp_vec;

  feature_stream_loader #(
    .WIDTH_A(WIDTH_A), .NUM_A(NUM_A), .OUTWIDTH(OUTWIDTH), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cls_inp(cls_inp), .cls_out(cls_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [OUTWIDTH:0] expect_cls(input logic [OUTWIDTH-1:0] c);
`ifdef OUT_PLUS_ONE_EN
    return {1'b0, c} + 3'd1;
`else
    return {1'b0, c};
`endif
  endfunction

  // Scoreboard monitor: one comparison per result handshake.
  initial begin
    logic [OUTWIDTH:0] e;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {125'd0, m_data}, 128'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("m_data", {125'd0, m_data}, {125'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [WIDTH_A-1:0] d);
    logic acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic set_slot(input int i, input logic [WIDTH_A-1:0] d);
    exp_vec[i*WIDTH_A +: WIDTH_A] = d;
  endtask

  task automatic wait_frames(input logic [15:0] target);
    int n;
    n = 0;
    while (frame_cnt != target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_wait", {112'd0, frame_cnt}, {112'd0, target});
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_s_ready", {127'd0, s_ready}, 128'd0);
    check("rst_m_valid", {127'd0, m_valid}, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_vec = '0;
  endtask

  initial begin
    int n, g, gaps, t0, stamp[3];
    logic [WIDTH_A-1:0] d;
    logic [OUTWIDTH-1:0] b2b_cls[3];
    b2b_cls[0] = 2'd0; b2b_cls[1] = 2'd1; b2b_cls[2] = 2'd3;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; cls_out = '0; m_ready = 1'b0;
    exp_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_s_ready", {127'd0, s_ready}, 128'd1);
    check("reset_m_valid", {127'd0, m_valid}, 128'd0);
    check("reset_m_data", {125'd0, m_data}, 128'd0);
    check("reset_cls_inp", {44'd0, cls_inp}, 128'd0);
    check("reset_frame_cnt", {112'd0, frame_cnt}, 128'd0);

    // Frame 1: features i%16, cls_out=2, sink stalled.
    cls_out = 2'd2;
    exp_q.push_back(expect_cls(2'd2));
    for (int i = 0; i < NUM_A; i++) begin
      d = WIDTH_A'(i % 16);
      set_slot(i, d);
      send(d);
    end
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, SETTLE);
    check("cls_inp_f1", {44'd0, cls_inp}, {44'd0, exp_vec});
    check("slot0", {124'd0, cls_inp[3:0]}, 128'd0);
    check("slot20", {124'd0, cls_inp[83:80]}, 128'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_m_valid", {127'd0, m_valid}, 128'd1);
      check("bp_s_ready", {127'd0, s_ready}, 128'd0);
      check("bp_m_data", {125'd0, m_data}, {125'd0, expect_cls(2'd2)});
      check("bp_cls_inp", {44'd0, cls_inp}, {44'd0, exp_vec});
    end
    check("bp_frame_cnt", {112'd0, frame_cnt}, 128'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_frame_cnt", {112'd0, frame_cnt}, 128'd1);
    check("release_s_ready", {127'd0, s_ready}, 128'd1);

    // Frame 2: random source gaps, cls_out=1.
    cls_out = 2'd1;
    exp_q.push_back(expect_cls(2'd1));
    gaps = 0;
    t0 = cyc;
    for (int i = 0; i < NUM_A; i++) begin
      g = $urandom_range(0, 2);
      s_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      gaps += g;
      d = WIDTH_A'((i * 7 + 3) % 16);
      set_slot(i, d);
      send(d);
    end
    s_valid = 1'b0;
    check("gap_cls_inp", {44'd0, cls_inp}, {44'd0, exp_vec});
    wait_frames(16'd2);
    check("gap_frame_time", cyc - t0, gaps + PERIOD);

    // Reset in the middle of a load, then a clean frame.
    for (int i = 0; i < 10; i++) send(WIDTH_A'(15 - i));
    s_valid = 1'b0;
    pulse_reset();
    check("mid_rst_cls_inp", {44'd0, cls_inp}, 128'd0);
    check("mid_rst_frame_cnt", {112'd0, frame_cnt}, 128'd0);
    check("mid_rst_m_data", {125'd0, m_data}, 128'd0);
    check("mid_rst_s_ready", {127'd0, s_ready}, 128'd1);
    check("mid_rst_m_valid", {127'd0, m_valid}, 128'd0);
    cls_out = 2'd3;
    exp_q.push_back(expect_cls(2'd3));
    for (int i = 0; i < NUM_A; i++) begin
      d = WIDTH_A'((i + 5) % 16);
      set_slot(i, d);
      send(d);
    end
    s_valid = 1'b0;
    check("clean_slot0", {124'd0, cls_inp[3:0]}, 128'd5);
    check("clean_cls_inp", {44'd0, cls_inp}, {44'd0, exp_vec});
    wait_frames(16'd1);

    // Three back-to-back frames with the sink always ready.
    pulse_reset();
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(expect_cls(b2b_cls[f]));
      for (int i = 0; i < NUM_A; i++) begin
        send(WIDTH_A'((i + f) % 16));
        if (i == 0) begin
          stamp[f] = cyc;
          cls_out = b2b_cls[f];
        end
      end
    end
    s_valid = 1'b0;
    wait_frames(16'd3);
    check("b2b_period_0", stamp[1] - stamp[0], PERIOD);
    check("b2b_period_1", stamp[2] - stamp[1], PERIOD);
    check("b2b_frame_cnt", {112'd0, frame_cnt}, 128'd3);
    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
